// File: rtl/sync_ram_bw.sv
`default_nettype none
// ============================================================================
//  Module   : sync_ram_bw
//  Purpose  : Single-port synchronous block RAM with per-byte write enables,
//             selectable read-during-write behaviour (write-first, read-first,
//             no-change), a dout_valid qualifier and an optional output
//             pipeline register.
//  Options  : `define SYNC_RAM_BW_PARITY_EN to store one even-parity bit per
//             byte lane and flag mismatches on readout (parity_err).
//  Ports    : clk        - clock, rising edge
//             rst        - synchronous active-high reset (output regs only)
//             en         - access enable
//             we         - per-byte write enables (any bit set = write)
//             addr       - word address
//             din        - write data
//             par_flip   - store inverted parity for lane 0 on a write
//             dout       - read data
//             dout_valid - dout was updated by an accepted access
//             parity_err - parity mismatch on the data presented on dout
//  Revision : 1.0 - initial release
// ============================================================================
module sync_ram_bw #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int READ_MODE  = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [WORD_WIDTH/8-1:0] we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [WORD_WIDTH-1:0]   din,
    input  logic                    par_flip,
    output logic [WORD_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    parity_err
);

    localparam int NB    = WORD_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_acc;
    logic                  w_wr;
    logic                  w_wr_first;
    logic                  w_load1;
    logic [WORD_WIDTH-1:0] w_old;
    logic [WORD_WIDTH-1:0] w_lane_mask;
    logic [WORD_WIDTH-1:0] w_merged;
    logic [WORD_WIDTH-1:0] w_q1_nxt;
    logic [WORD_WIDTH-1:0] r_q1;
    logic                  r_v1;

    // Reset blocks the access outright, including its write.
    assign w_acc      = en & ~rst;
    assign w_wr       = |we;
    // Only write-first returns the merged word; the other modes see the old one.
    assign w_wr_first = w_wr & (READ_MODE == 0);
    // No-change mode leaves stage 1 untouched on a write.
    assign w_load1    = w_acc & (~w_wr | (READ_MODE != 2));
    assign w_old      = r_mem[addr];

    generate
        for (genvar i = 0; i < NB; i++) begin : g_lane_mask
            assign w_lane_mask[8*i +: 8] = {8{we[i]}};
        end
    endgenerate

    assign w_merged = (din & w_lane_mask) | (w_old & ~w_lane_mask);
    assign w_q1_nxt = w_wr_first ? w_merged : w_old;

    // Array contents are never reset.
    always_ff @(posedge clk) begin : p_mem_write
        if (w_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (we[i]) begin
                    r_mem[addr][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin : p_stage1
        if (rst) begin
            r_q1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_load1;
            if (w_load1) begin
                r_q1 <= w_q1_nxt;
            end
        end
    end

    // Optional output register: only captures real data so dout stays stable
    // while dout_valid is low.
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WORD_WIDTH-1:0] r_q2;
            logic                  r_v2;

            always_ff @(posedge clk) begin : p_stage2
                if (rst) begin
                    r_q2 <= '0;
                    r_v2 <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_q2 <= r_q1;
                    end
                end
            end

            assign dout       = r_q2;
            assign dout_valid = r_v2;
        end else begin : g_no_out_reg
            assign dout       = r_q1;
            assign dout_valid = r_v1;
        end
    endgenerate

`ifdef SYNC_RAM_BW_PARITY_EN
    localparam logic [NB-1:0] c_lane0 = NB'(1);

    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] w_par_din;
    logic [NB-1:0] w_par_store;
    logic [NB-1:0] w_par_old;
    logic [NB-1:0] w_par_nxt;
    logic [NB-1:0] w_par_out;
    logic [NB-1:0] w_par_chk;
    logic [NB-1:0] r_p1;

    generate
        for (genvar i = 0; i < NB; i++) begin : g_par_lane
            assign w_par_din[i] = ^din[8*i +: 8];
            // Recompute on the presented word so the flag tracks dout exactly.
            assign w_par_chk[i] = (^dout[8*i +: 8]) ^ w_par_out[i];
        end
    endgenerate

    assign w_par_store = w_par_din ^ (par_flip ? c_lane0 : '0);
    assign w_par_old   = r_par[addr];
    // Freshly written lanes returned write-first carry true parity, never the
    // flipped value.
    assign w_par_nxt   = w_wr_first ? ((w_par_din & we) | (w_par_old & ~we))
                                    : w_par_old;

    always_ff @(posedge clk) begin : p_par_write
        if (w_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (we[i]) begin
                    r_par[addr][i] <= w_par_store[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin : p_par_stage1
        if (rst) begin
            r_p1 <= '0;
        end else if (w_load1) begin
            r_p1 <= w_par_nxt;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_par_out_reg
            logic [NB-1:0] r_p2;

            always_ff @(posedge clk) begin : p_par_stage2
                if (rst) begin
                    r_p2 <= '0;
                end else if (r_v1) begin
                    r_p2 <= r_p1;
                end
            end

            assign w_par_out = r_p2;
        end else begin : g_par_no_out_reg
            assign w_par_out = r_p1;
        end
    endgenerate

    assign parity_err = |w_par_chk;
`else
    logic w_unused_par_flip;
    assign w_unused_par_flip = par_flip;
    assign parity_err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/sync_ram_bw.md
# sync_ram_bw

Parametrised single-port synchronous block RAM with per-byte write enables, selectable read-during-write behaviour and an optional output pipeline register. It generalises the write-first SSRAM model used behind the AHB-to-SSRAM bridge. It adds a `dout_valid` qualifier and optional per-byte parity checking. It maps onto FPGA block RAM, including the output register when OUT_REG=1.

## Interface
- `WORD_WIDTH`, default 32: data width in bits; must be a multiple of 8. NB = WORD_WIDTH/8 byte lanes.
- `ADDR_WIDTH`, default 10: address width; depth = 2**ADDR_WIDTH words.
- `READ_MODE`, default 0: read-during-write behaviour. 0 = write-first, 1 = read-first, 2 = no-change.
- `OUT_REG`, default 0: 0 = read latency 1; 1 = extra output register, read latency 2.
- `clk` input 1: clock; all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high; clears output regs only, not array contents.
- `en` input 1: access enable.
- `we` input NB: per-byte write enables; bit i covers din[8i+7:8i]; any bit set makes the access a write.
- `addr` input ADDR_WIDTH: word address.
- `din` input WORD_WIDTH: write data.
- `par_flip` input 1: test hook; on a write, stores inverted parity for byte lane 0 (parity build only).
- `dout` output WORD_WIDTH: read data.
- `dout_valid` output 1: `dout` updated by an accepted access this cycle.
- `parity_err` output 1: parity mismatch on the data currently presented; qualified by `dout_valid`.

## Operation
- An access is accepted when `en`=1 and `rst`=0. When `rst`=1, writes are suppressed and no access is accepted.
- Write: for each lane i with we[i]=1, RAM[addr] lane i <= din lane i. Unselected lanes keep their old contents.
- Stage-1 data register `q1` on an accepted access:
  - read (`we`=0): q1 <= RAM[addr].
  - write, READ_MODE 0: q1 <= merged word (new lanes from `din`, others old contents).
  - write, READ_MODE 1: q1 <= old RAM[addr].
  - write, READ_MODE 2: q1 holds; v1 stays 0.
- `v1` <= 1 for an accepted read, or an accepted write in modes 0 and 1; otherwise 0.
- `en`=0: q1 holds its value; v1 <= 0.
- OUT_REG=0: `dout` = q1, `dout_valid` = v1.
- OUT_REG=1: q2 <= q1 when v1=1, otherwise q2 holds; v2 <= v1. `dout` = q2, `dout_valid` = v2.
- Out-of-range addresses cannot occur: depth is a full power of two.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `parity_err`=0, q1/q2/v1/v2 = 0. Array contents are undefined and not cleared.
- Latency from accepted access to `dout_valid`: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
- Throughput: one access per cycle, back-to-back, with no bubbles.
- Read of an address written in the previous cycle returns the new data.
- Reset mid-operation: accesses already in flight are discarded. `dout_valid`=0 in the cycle after `rst` is sampled high, and the access presented in that cycle is ignored.
- `dout` is held stable whenever `dout_valid`=0, apart from the reset clear.

## Configuration
- Macro `SYNC_RAM_BW_PARITY_EN`.
- Defined:
  - Array stores WORD_WIDTH+NB bits; one even-parity bit per byte, computed on write.
  - `par_flip`=1 during a write inverts the stored parity of lane 0 for the lanes written.
  - On readout, parity is recomputed per lane. `parity_err`=1 when any lane mismatches, pipelined in step with `dout`/`dout_valid`.
  - Write-first returns of newly written lanes use freshly computed parity and never flag an error.
- Not defined: no parity storage; `par_flip` is ignored; `parity_err` is tied 0.

## Test plan
- Reset then idle (OUT_REG=0): `dout`=0, `dout_valid`=0; write 0xDEADBEEF to addr 5, read addr 5 -> `dout`=0xDEADBEEF with `dout_valid`=1 exactly one cycle after the read.
- Byte enables: write 0x11223344 to addr 3, then write `we`=4'b0101 with 0xAABBCCDD -> read returns 0x11BB33DD.
- READ_MODE sweep, addr 7 holding 0x0 then write 0x12345678:
  - mode 0 -> same-cycle `dout`=0x12345678.
  - mode 1 -> `dout`=0x0.
  - mode 2 -> `dout` unchanged and `dout_valid`=0.
- OUT_REG=1 back-to-back reads of addrs 0..3 (preloaded 0xA0..0xA3) -> `dout` 0xA0..0xA3 on four consecutive cycles, starting 2 cycles after the first read.
- Reset mid-stream: assert `rst` with a read in flight (OUT_REG=1) -> `dout_valid` stays 0 and `dout`=0. Data written before reset reads back intact afterwards.
- Parity build: write 0x000000FF with `par_flip`=1 to addr 9, read addr 9 -> `parity_err`=1 with `dout_valid`. Rewrite without the flip -> `parity_err`=0.
